mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/rr_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory arbiter and its RAM.
package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT    = 32;
  localparam int DATA_W_DEFAULT    = 32;
  localparam int MEM_WORDS_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_LSU    = 1'b1
  } port_id_t;

  // The port that did not win last time gets priority on contention.
  function automatic port_id_t other_port(input port_id_t p);
    port_id_t r;
    if (p == PORT_IFETCH) begin
      r = PORT_LSU;
    end else begin
      r = PORT_IFETCH;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter.
// slave: the arbiter itself. master: core fetch/LSU logic plus the RAM read path.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; reusable for other shared resources.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  output port_id_t   grant_id,
  output logic       grant_valid
);

  // Sole requester wins; on contention the port that lost last time wins.
  always_comb begin
    grant_id    = PORT_IFETCH;
    grant_valid = 1'b0;
    case (req)
      2'b01: begin
        grant_id    = PORT_IFETCH;
        grant_valid = 1'b1;
      end
      2'b10: begin
        grant_id    = PORT_LSU;
        grant_valid = 1'b1;
      end
      2'b11: begin
        grant_id    = other_port(last_grant);
        grant_valid = 1'b1;
      end
      default: begin
        grant_id    = PORT_IFETCH;
        grant_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM between instruction fetch (port 0) and
// load/store (port 1). Each grant runs IDLE -> ACCESS -> RESP, one cycle each.
// The interface instance must use the same ADDR_W/DATA_W as this module.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  // Limit widened to the full address width so no upper word bits get dropped.
  localparam logic [ADDR_W-1:0] WORDS_LIMIT = ADDR_W'(MEM_WORDS);

  function automatic logic in_range(input logic [ADDR_W-3:0] word);
    return ({2'b00, word} < WORDS_LIMIT);
  endfunction

  state_t            state_q, state_d;
  port_id_t          owner_q, owner_d;
  port_id_t          last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;

  port_id_t          grant_id;
  logic              grant_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_ok;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant_q),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  assign addr_ok = in_range(addr_q[ADDR_W-1:2]);

  // Route the winning port's command fields.
  always_comb begin
    if (grant_id == PORT_LSU) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end else begin
      sel_we    = bus.we0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
    end
  end

  // Next-state and registered-output logic of the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_addr_d   = '0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = '0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d     = grant_id;
          we_d        = sel_we;
          addr_d      = sel_addr;
          mem_addr_d  = sel_addr;
          mem_we_d    = sel_we & in_range(sel_addr[ADDR_W-1:2]);
          mem_wdata_d = sel_wdata;
          state_d     = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Ack/err are set here so they are flop outputs during RESP.
        if (owner_q == PORT_LSU) begin
          ack1_d = 1'b1;
          err1_d = ~addr_ok;
          if (!we_q) begin
            rdata1_d = addr_ok ? bus.mem_rdata : '0;
          end else begin
            rdata1_d = rdata1_q;
          end
        end else begin
          ack0_d = 1'b1;
          err0_d = ~addr_ok;
          if (!we_q) begin
            rdata0_d = addr_ok ? bus.mem_rdata : '0;
          end else begin
            rdata0_d = rdata0_q;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves port 1 as last winner so port 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= PORT_IFETCH;
      last_grant_q <= PORT_LSU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural RAM.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          port;
    bit          we;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  bit          allow_withdraw = 1'b0;
  exp_t        sb [$];
  req_t        cur [2];
  bit          pend [2];
  logic [31:0] m_rdata [2];
  int          m_last;
  logic [31:0] ref_mem [64];
  logic [31:0] ram [64];
  bit          ram_init_done = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: combinational read, write at the rising edge.
  assign bus.mem_rdata = (bus.mem_addr[31:8] == 24'h0) ? ram[bus.mem_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      ram_init_done <= 1'b1;
    end else if (bus.mem_we && bus.mem_addr[31:8] == 24'h0) begin
      ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  // Monitor: RAM-side bus per cycle, and every ack against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc + 1) begin
        e = sb[0];
        chk("access_we", {31'b0, bus.mem_we}, {31'b0, e.we & ~e.err});
        chk("access_addr", bus.mem_addr, e.addr);
        if (e.we && !e.err) chk("access_wdata", bus.mem_wdata, e.wdata);
      end else begin
        chk("idle_we", {31'b0, bus.mem_we}, 32'h0);
        chk("idle_addr", bus.mem_addr, 32'h0);
      end
      if (bus.ack0 && bus.ack1) chk("dual_ack", 32'h1, 32'h0);
      if (bus.ack0 || bus.ack1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", bus.ack1 ? 32'h1 : 32'h0, 32'(e.port));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.port == 1) begin
            chk("err1", {31'b0, bus.err1}, {31'b0, e.err});
            chk("rdata1", bus.rdata1, e.rdata);
          end else begin
            chk("err0", {31'b0, bus.err0}, {31'b0, e.err});
            chk("rdata0", bus.rdata0, e.rdata);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("ack_missing", 32'h0, 32'h1);
      end
    end
  end

  task automatic drive(input int p, input bit en);
    if (p == 0) begin
      bus.req0 = en; bus.we0 = cur[0].we; bus.addr0 = cur[0].addr; bus.wdata0 = cur[0].wdata;
    end else begin
      bus.req1 = en; bus.we1 = cur[1].we; bus.addr1 = cur[1].addr; bus.wdata1 = cur[1].wdata;
    end
  endtask

  task automatic set_req(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    cur[p].we = we; cur[p].addr = addr; cur[p].wdata = wdata;
    pend[p] = 1'b1;
    drive(p, 1'b1);
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] w;
    logic [31:0] lo;
    int k;
    k  = $urandom_range(0, 9);
    lo = $urandom_range(0, 3);
    if (k < 6)       w = $urandom_range(0, 63);
    else if (k < 8)  w = $urandom_range(60, 67);
    else if (k == 8) w = 32'h2000_0000 | 32'($urandom_range(0, 63));
    else             w = 32'd64;
    return {w[29:0], lo[1:0]};
  endfunction

  // Called just after a rising edge while the arbiter idles with a request pending.
  task automatic issue_one();
    int          w;
    bit          got;
    exp_t        e;
    logic [31:0] word;
    bit          inr;
    if (pend[0] && pend[1]) w = (m_last == 0) ? 1 : 0;
    else if (pend[0])       w = 0;
    else                    w = 1;
    m_last = w;
    word = cur[w].addr >> 2;
    inr  = (word < 32'd64);
    if (!cur[w].we)  m_rdata[w] = inr ? ref_mem[word[5:0]] : 32'h0;
    else if (inr)    ref_mem[word[5:0]] = cur[w].wdata;
    e.port = w; e.we = cur[w].we; e.err = !inr; e.addr = cur[w].addr;
    e.wdata = cur[w].wdata; e.rdata = m_rdata[w]; e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    if (allow_withdraw && $urandom_range(0, 3) == 0) begin
      if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((w == 0 && bus.ack0) || (w == 1 && bus.ack1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 32'h0, 32'h1);
    pend[w] = 1'b0;
    drive(w, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && (pend[0] || pend[1]); i++) issue_one();
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0; bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    pend[0] = 1'b0; pend[1] = 1'b0;
    m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
    m_last = 1;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_ack0", {31'b0, bus.ack0}, 32'h0);
    chk("rst_ack1", {31'b0, bus.ack1}, 32'h0);
    chk("rst_err0", {31'b0, bus.err0}, 32'h0);
    chk("rst_err1", {31'b0, bus.err1}, 32'h0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata0", bus.rdata0, 32'h0);
    chk("rst_rdata1", bus.rdata1, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Contention straight after reset, then directed reads/writes.
    set_req(0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 32'h4, 32'h1234_5678);
    drain();
    set_req(0, 1'b0, 32'h8, 32'h0);            drain();
    set_req(1, 1'b1, 32'h3C, 32'hCAFE_F00D);   drain();
    set_req(0, 1'b0, 32'h3D, 32'h0);           drain();
    set_req(1, 1'b1, 32'h100, 32'hFFFF_FFFF);  drain();
    set_req(1, 1'b0, 32'h100, 32'h0);          drain();
    set_req(0, 1'b0, 32'h4, 32'h0);            drain();

    // Sustained contention: both ports always requesting.
    for (int t = 0; t < 12; t++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) set_req(p, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
      issue_one();
    end
    drain();

    // Random traffic, including out-of-range addresses and early req drops.
    allow_withdraw = 1'b1;
    for (int t = 0; t < 300; t++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) != 0) set_req(p, 1'($urandom_range(0, 1)), gen_addr(), $urandom);
      if (pend[0] || pend[1]) issue_one();
      else begin @(posedge clk); #1; end
    end
    drain();
    allow_withdraw = 1'b0;

    // Reset while a write is in ACCESS: no RAM write, no ack.
    set_req(1, 1'b1, 32'h20, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    chk("rst_mid_we_before", {31'b0, bus.mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'b0, bus.mem_we}, 32'h0);
    chk("rst_mid_ack0", {31'b0, bus.ack0}, 32'h0);
    chk("rst_mid_ack1", {31'b0, bus.ack1}, 32'h0);
    chk("rst_mid_addr", bus.mem_addr, 32'h0);
    pend[1] = 1'b0; drive(1, 1'b0);
    m_last = 1; m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_mid_rdata1", bus.rdata1, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h20, 32'h0);           drain();
    set_req(0, 1'b0, 32'h24, 32'h0);
    set_req(1, 1'b1, 32'h28, 32'h0BAD_F00D);   drain();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    for (int i = 0; i < 64; i++) chk($sformatf("ram[%0d]", i), ram[i], ref_mem[i]);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
